// File: rtl/serial_subtractor.sv
// Bit-serial {Bout,Diff} = A - B - Bin, LSB first; done pulses WIDTH cycles after the accepting edge.
// start is ignored while busy (no queueing); SERIAL_SUB_OVF_EN adds the registered signed-overflow output Ovf.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    logic bit_a, bit_b, bit_d, bit_br;

    // One full-subtractor cell working on the current LSBs of the operand shifters.
    always_comb begin
        bit_a  = a_q[0];
        bit_b  = b_q[0];
        bit_d  = bit_a ^ bit_b ^ br_q;
        bit_br = (~bit_a & bit_b) | (~bit_a & br_q) | (bit_b & br_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = Bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {bit_d, res_q[WIDTH-1:1]};
                br_d  = bit_br;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    diff_d  = {bit_d, res_q[WIDTH-1:1]};
                    bout_d  = bit_br;
                    done_d  = 1'b1;
                    // On the last bit the shifters hold the original operand MSBs.
                    ovf_d   = (bit_a ^ bit_b) & (bit_d ^ bit_a);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign Diff = diff_q;
    assign Bout = bout_q;

`ifdef SERIAL_SUB_OVF_EN
    assign Ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH = 4); inputs driven and outputs sampled 1 ns after the rising edge.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       Bin;
    logic       busy;
    logic       done;
    logic [3:0] Diff;
    logic       Bout;
`ifdef SERIAL_SUB_OVF_EN
    logic       Ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
        .Bout  (Bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one accepting edge; returns busy as seen right after it.
    task automatic accept(input logic [3:0] a, input logic [3:0] b, input logic bin,
                          output logic busy_after);
        start = 1'b1;
        A     = a;
        B     = b;
        Bin   = bin;
        step();
        busy_after = busy;
        start = 1'b0;
        A     = 4'hx;
        B     = 4'hx;
        Bin   = 1'bx;
    endtask

    // Waits for done with a bound; cyc = edges after the accepting edge (20 on timeout).
    task automatic wait_done(output int cyc, output logic busy_ok);
        cyc     = 0;
        busy_ok = 1'b1;
        while (cyc < 20) begin
            step();
            cyc++;
            if (done) break;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; A = 4'd0; B = 4'd0; Bin = 1'b0;
        step();
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (Diff !== 4'd0) begin errors++; $display("FAIL reset_diff got %0d want 0", Diff); end
        checks++; if (Bout !== 1'b0) begin errors++; $display("FAIL reset_bout got %0b want 0", Bout); end
`ifdef SERIAL_SUB_OVF_EN
        checks++; if (Ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", Ovf); end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic b0, bok;
        int   cyc;
        accept(4'd9, 4'd3, 1'b0, b0);
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL basic_busy_e0 got %0b want 1", b0); end
        wait_done(cyc, bok);
        checks++; if (cyc != 4) begin errors++; $display("FAIL basic_latency got %0d want 4", cyc); end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL basic_busy_run got %0b want 1", bok); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %0b want 0", busy); end
        checks++; if (Diff !== 4'd6) begin errors++; $display("FAIL basic_diff got %0d want 6", Diff); end
        checks++; if (Bout !== 1'b0) begin errors++; $display("FAIL basic_bout got %0b want 0", Bout); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %0b want 0", done); end
        checks++; if (Diff !== 4'd6) begin errors++; $display("FAIL basic_diff_hold got %0d want 6", Diff); end
    endtask

    task automatic test_borrow();
        logic b0, bok;
        int   cyc;
        accept(4'd3, 4'd9, 1'b0, b0);
        wait_done(cyc, bok);
        checks++; if (Diff !== 4'd10) begin errors++; $display("FAIL borrow1_diff got %0d want 10", Diff); end
        checks++; if (Bout !== 1'b1) begin errors++; $display("FAIL borrow1_bout got %0b want 1", Bout); end
        step();
        accept(4'd0, 4'd0, 1'b1, b0);
        wait_done(cyc, bok);
        checks++; if (Diff !== 4'd15) begin errors++; $display("FAIL borrow2_diff got %0d want 15", Diff); end
        checks++; if (Bout !== 1'b1) begin errors++; $display("FAIL borrow2_bout got %0b want 1", Bout); end
        step();
    endtask

    task automatic test_ignore_busy();
        logic b0;
        int   ndone;
        logic [3:0] d_at_done;
        logic       bo_at_done;
        logic       mid_ok;
        ndone = 0; d_at_done = 4'hx; bo_at_done = 1'bx; mid_ok = 1'b1;
        accept(4'd5, 4'd2, 1'b0, b0);
        for (int i = 1; i <= 12; i++) begin
            if (i == 2) begin start = 1'b1; A = 4'd15; B = 4'd0; Bin = 1'b0; end
            if (i == 3) begin start = 1'b0; end
            step();
            if (i < 4 && Diff !== 4'd15) mid_ok = 1'b0;
            if (done) begin ndone++; d_at_done = Diff; bo_at_done = Bout; end
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_ndone got %0d want 1", ndone); end
        checks++; if (d_at_done !== 4'd3) begin errors++; $display("FAIL ignore_diff got %0d want 3", d_at_done); end
        checks++; if (bo_at_done !== 1'b0) begin errors++; $display("FAIL ignore_bout got %0b want 0", bo_at_done); end
        checks++; if (mid_ok !== 1'b1) begin errors++; $display("FAIL ignore_diff_stable got %0b want 1", mid_ok); end
    endtask

    task automatic test_abort();
        logic b0, bok;
        int   cyc, ndone;
        accept(4'd7, 4'd1, 1'b0, b0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %0b want 0", done); end
        checks++; if (Diff !== 4'd0) begin errors++; $display("FAIL abort_diff got %0d want 0", Diff); end
        checks++; if (Bout !== 1'b0) begin errors++; $display("FAIL abort_bout got %0b want 0", Bout); end
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", ndone); end
        accept(4'd7, 4'd1, 1'b0, b0);
        wait_done(cyc, bok);
        checks++; if (cyc != 4) begin errors++; $display("FAIL abort_rerun_latency got %0d want 4", cyc); end
        checks++; if (Diff !== 4'd6) begin errors++; $display("FAIL abort_rerun_diff got %0d want 6", Diff); end
        step();
    endtask

    // start held high: accept E0, done after E4, re-accept in the done cycle, so pulses 5 edges apart.
    task automatic test_back_to_back();
        int   pos [3];
        int   n;
        logic vals_ok, gap_ok, prev_done;
        n = 0; vals_ok = 1'b1; gap_ok = 1'b1; prev_done = 1'b0;
        pos[0] = -1; pos[1] = -1; pos[2] = -1;
        start = 1'b1; A = 4'd12; B = 4'd4; Bin = 1'b1;
        step();
        for (int i = 1; i <= 15; i++) begin
            step();
            if (prev_done && busy !== 1'b1) gap_ok = 1'b0;
            prev_done = done;
            if (done) begin
                if (n < 3) pos[n] = i;
                n++;
                if (Diff !== 4'd7 || Bout !== 1'b0) vals_ok = 1'b0;
            end
        end
        start = 1'b0;
        checks++; if (n != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", n); end
        checks++; if (pos[0] != 4) begin errors++; $display("FAIL b2b_first got %0d want 4", pos[0]); end
        checks++; if (pos[1] != 9) begin errors++; $display("FAIL b2b_second got %0d want 9", pos[1]); end
        checks++; if (pos[2] != 14) begin errors++; $display("FAIL b2b_third got %0d want 14", pos[2]); end
        checks++; if (vals_ok !== 1'b1) begin errors++; $display("FAIL b2b_values got %0b want 1", vals_ok); end
        checks++; if (gap_ok !== 1'b1) begin errors++; $display("FAIL b2b_no_gap got %0b want 1", gap_ok); end
        for (int i = 0; i < 6; i++) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain_busy got %0b want 0", busy); end
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf();
        logic b0, bok;
        int   cyc;
        accept(4'd8, 4'd1, 1'b0, b0);
        wait_done(cyc, bok);
        checks++; if (Diff !== 4'd7) begin errors++; $display("FAIL ovf1_diff got %0d want 7", Diff); end
        checks++; if (Bout !== 1'b0) begin errors++; $display("FAIL ovf1_bout got %0b want 0", Bout); end
        checks++; if (Ovf !== 1'b1) begin errors++; $display("FAIL ovf1_ovf got %0b want 1", Ovf); end
        step();
        accept(4'd2, 4'd1, 1'b0, b0);
        wait_done(cyc, bok);
        checks++; if (Diff !== 4'd1) begin errors++; $display("FAIL ovf2_diff got %0d want 1", Diff); end
        checks++; if (Ovf !== 1'b0) begin errors++; $display("FAIL ovf2_ovf got %0b want 0", Ovf); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_ignore_busy();
        test_abort();
        test_back_to_back();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
